// File: rtl/logic_unit_pipe.sv
// logic_unit_pipe: pipelined 8-op bitwise logic unit with a result FIFO and an
// accumulator that can replace operand A and capture each result.
// Results become visible one cycle after acceptance; nothing passes straight
// from the operand inputs to res.
module logic_unit_pipe #(
    parameter int WIDTH      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [2:0]                   op,
    input  logic [WIDTH-1:0]             a,
    input  logic [WIDTH-1:0]             b,
    input  logic                         acc_en,
    input  logic                         acc_clr,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             res,
    output logic                         zero,
    output logic [$clog2(FIFO_DEPTH):0]  level,
    output logic [WIDTH-1:0]             acc
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] last_res;
    logic [WIDTH-1:0] acc_operand;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] result;
    logic             push;
    logic             pop;

    // Handshake qualifiers; a full FIFO refuses a beat even if a pop happens in the same cycle.
    always_comb begin
        in_ready  = (level != FULL_LEVEL);
        out_valid = (level != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
    end

    // Operand A selection: a same-cycle clear makes the accumulator read as zero.
    always_comb begin
        acc_operand = acc_clr ? '0 : acc;
        op_a        = acc_en ? acc_operand : a;
    end

    // The eight bitwise operations.
    always_comb begin
        result = '0;
        unique case (op)
            3'b000:  result = op_a & b;
            3'b001:  result = op_a | b;
            3'b010:  result = op_a ^ b;
            3'b011:  result = ~(op_a | b);
            3'b100:  result = ~(op_a & b);
            3'b101:  result = ~(op_a ^ b);
            3'b110:  result = op_a & ~b;
            default: result = b;
        endcase
    end

    // Result storage; contents need no reset because level gates their visibility.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= result;
        end
    end

    // Pointers, occupancy and the last popped value shown while the FIFO is empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            last_res <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + PW'(1);
                last_res <= mem[rd_ptr];
            end
            if (push && !pop) begin
                level <= level + LW'(1);
            end else if (pop && !push) begin
                level <= level - LW'(1);
            end
        end
    end

    // Accumulator: an accepted accumulate beat wins over a plain clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (push && acc_en) begin
            acc <= result;
        end else if (acc_clr) begin
            acc <= '0;
        end
    end

    // Head presentation: live head entry when valid, otherwise the value most recently popped.
    always_comb begin
        res  = out_valid ? mem[rd_ptr] : last_res;
        zero = (res == '0);
    end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// tb_logic_unit_pipe: directed vectors for logic_unit_pipe; expected results are
// queued when a beat is accepted and checked by a monitor as the FIFO head pops.
module tb_logic_unit_pipe;

    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_XOR  = 3'b010;
    localparam logic [2:0] OP_NOR  = 3'b011;
    localparam logic [2:0] OP_NAND = 3'b100;
    localparam logic [2:0] OP_XNOR = 3'b101;
    localparam logic [2:0] OP_ANDN = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             acc_en;
    logic             acc_clr;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic [2:0]       level;
    logic [WIDTH-1:0] acc;

    int numChecks = 0;
    int numFails  = 0;
    logic [WIDTH-1:0] sbQueue [$];

    logic_unit_pipe #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .acc_en(acc_en), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .res(res), .zero(zero),
        .level(level), .acc(acc)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Monitor: every pop of the FIFO head is compared against the oldest expected result.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            numChecks++;
            if (sbQueue.size() == 0) begin
                numFails++;
                $display("[TB] FAIL pop_unexpected: res=%h with no expected result queued", res);
            end else begin
                logic [WIDTH-1:0] exp;
                exp = sbQueue.pop_front();
                if (res !== exp || zero !== (exp == '0)) begin
                    numFails++;
                    $display("[TB] FAIL pop_result: got res=%h zero=%b, expected res=%h zero=%b",
                             res, zero, exp, (exp == '0));
                end
            end
        end
    end

    // Direct comparison of a sampled value against its required value.
    task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                               input logic [WIDTH-1:0] expected);
        numChecks++;
        if (actual !== expected) begin
            numFails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Offer one beat and wait (bounded) for it to be accepted; queue its expected result.
    task automatic applyStimulus(input logic [2:0] opIn, input logic [WIDTH-1:0] aIn,
                                 input logic [WIDTH-1:0] bIn, input logic accEnIn,
                                 input logic accClrIn, input logic [WIDTH-1:0] expRes);
        bit accepted;
        accepted = 1'b0;
        op       = opIn;
        a        = aIn;
        b        = bIn;
        acc_en   = accEnIn;
        acc_clr  = accClrIn;
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 50 && !accepted; cyc++) begin
            @(negedge clk);
            if (in_ready) begin
                sbQueue.push_back(expRes);
                accepted = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        acc_en   = 1'b0;
        acc_clr  = 1'b0;
        if (!accepted) begin
            numChecks++;
            numFails++;
            $display("[TB] FAIL accept_timeout: beat op=%b b=%h never accepted", opIn, bIn);
        end
    endtask

    // Wait (bounded) for all queued results to be popped.
    task automatic waitDrain();
        int cyc;
        cyc = 0;
        while ((sbQueue.size() != 0 || out_valid) && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        numChecks++;
        if (sbQueue.size() != 0 || out_valid) begin
            numFails++;
            $display("[TB] FAIL drain_timeout: %0d results still expected, out_valid=%b",
                     sbQueue.size(), out_valid);
        end
    endtask

    // Directed test sequence.
    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        op        = 3'b000;
        a         = '0;
        b         = '0;
        acc_en    = 1'b0;
        acc_clr   = 1'b0;
        out_ready = 1'b0;

        // Reset state, then idle after release.
        #12;
        checkOutput("rst_in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_level", 32'(level), 32'd0);
        checkOutput("rst_acc", acc, 32'h0);
        checkOutput("rst_zero", 32'(zero), 32'd1);
        checkOutput("rst_res", res, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checkOutput("idle_level", 32'(level), 32'd0);
        checkOutput("idle_out_valid", 32'(out_valid), 32'd0);
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        // All operations with a fixed operand pair, consumer always ready.
        out_ready = 1'b1;
        applyStimulus(OP_NOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, 32'h000F_0000);
        checkOutput("latency_out_valid", 32'(out_valid), 32'd1);
        checkOutput("latency_res", res, 32'h000F_0000);
        applyStimulus(OP_AND,  32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, 32'h00F0_1234);
        applyStimulus(OP_OR,   32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, 32'hFFF0_FFFF);
        applyStimulus(OP_XOR,  32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, 32'hFF00_EDCB);
        applyStimulus(OP_NAND, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, 32'hFF0F_EDCB);
        applyStimulus(OP_XNOR, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, 32'h00FF_1234);
        applyStimulus(OP_ANDN, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, 32'hF000_0000);
        applyStimulus(OP_PASS, 32'hF0F0_1234, 32'h0FF0_FFFF, 1'b0, 1'b0, 32'h0FF0_FFFF);
        waitDrain();
        checkOutput("empty_hold_res", res, 32'h0FF0_FFFF);

        // Backpressure: fill the FIFO, hold the fifth beat, then release the consumer.
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 5; i++) begin
                    applyStimulus(OP_PASS, 32'h0, 32'(i), 1'b0, 1'b0, 32'(i));
                end
            end
            begin
                repeat (8) @(posedge clk);
                #1;
                checkOutput("full_level", 32'(level), 32'd4);
                checkOutput("full_in_ready", 32'(in_ready), 32'd0);
                checkOutput("full_head_hold", res, 32'h1);
                out_ready = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("full_pop_no_push_level", 32'(level), 32'd3);
            end
        join
        waitDrain();

        // Accumulator: clear, then OR in one bit per beat, then clear it via ANDN.
        acc_clr = 1'b1;
        @(posedge clk);
        #1 acc_clr = 1'b0;
        checkOutput("acc_cleared", acc, 32'h0);
        applyStimulus(OP_OR, 32'hDEAD_BEEF, 32'h1, 1'b1, 1'b0, 32'h1);
        applyStimulus(OP_OR, 32'hDEAD_BEEF, 32'h2, 1'b1, 1'b0, 32'h3);
        applyStimulus(OP_OR, 32'hDEAD_BEEF, 32'h4, 1'b1, 1'b0, 32'h7);
        applyStimulus(OP_OR, 32'hDEAD_BEEF, 32'h8, 1'b1, 1'b0, 32'hF);
        checkOutput("acc_after_or", acc, 32'h0000_000F);
        applyStimulus(OP_ANDN, 32'hDEAD_BEEF, 32'hF, 1'b1, 1'b0, 32'h0);
        checkOutput("acc_after_andn", acc, 32'h0);
        waitDrain();
        checkOutput("zero_after_andn", 32'(zero), 32'd1);

        // Clear in the same cycle as an accepted accumulate beat.
        applyStimulus(OP_PASS, 32'h0, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF);
        checkOutput("acc_all_ones", acc, 32'hFFFF_FFFF);
        applyStimulus(OP_OR, 32'h1234_5678, 32'h0000_00A5, 1'b1, 1'b1, 32'h0000_00A5);
        checkOutput("acc_clr_with_beat", acc, 32'h0000_00A5);
        waitDrain();

        // Reset mid-stream discards queued results and the accumulator.
        out_ready = 1'b0;
        applyStimulus(OP_XOR, 32'h0, 32'h11, 1'b0, 1'b0, 32'h11);
        applyStimulus(OP_XOR, 32'h0, 32'h22, 1'b0, 1'b0, 32'h22);
        applyStimulus(OP_XOR, 32'h0, 32'h33, 1'b0, 1'b0, 32'h33);
        checkOutput("pre_reset_level", 32'(level), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        sbQueue.delete();
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_level", 32'(level), 32'd0);
        checkOutput("midrst_acc", acc, 32'h0);
        checkOutput("midrst_res", res, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        applyStimulus(OP_NOR, 32'h0, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF);
        waitDrain();

        $display("== %0d vectors applied, %0d miscompares ==", numChecks, numFails);
        $finish;
    end

endmodule
